// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the unified memory arbiter.
// Imported by the arbiter, its pick sub-module and the bench.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core-side valid/ready memory port with abort flag.
// mem_bus_if: the single memory-side port (no error return).
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            we;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output valid, addr, wdata, we,
    input  ready, rdata, err
  );

  modport slave (
    input  valid, addr, wdata, we,
    output ready, rdata, err
  );
endinterface

interface mem_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            we;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output valid, addr, wdata, we,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, we,
    output ready, rdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: two-requester winner selection, round-robin or fixed.
// Output is only meaningful when at least one valid is set.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       rr_last,
  input  logic       mode,
  output logic       winner
);

  always_comb begin
    winner = PORT_D;
    unique case (1'b1)
      (valid == 2'b11): winner = mode ? PORT_D : ~rr_last;
      (valid == 2'b10): winner = PORT_I;
      default:          winner = PORT_D;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the data and instruction
// ports; one transaction in flight, ended by memory ready or timeout abort.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIO_MODE      = PRIO_RR,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  s0,
  mem_arbiter_if.slave  s1,
  mem_bus_if.master     mem,
  output logic          busy
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic FIXED = (PRIO_MODE == PRIO_FIXED);

  arb_state_e state;
  arb_state_e state_nx;

  logic                  grant;
  logic                  rr_last;
  logic                  winner;
  logic                  timeout;
  logic                  in_busy;
  logic                  take;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            we_q;

  logic                  rsp_ready;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  mem_arb_pick u_pick (
    .valid   ({s1.valid, s0.valid}),
    .rr_last (rr_last),
    .mode    (FIXED),
    .winner  (winner)
  );

  assign timeout = TMO_EN && (cnt == CNT_LAST);
  assign in_busy = (state == ARB_BUSY);
  assign take    = (state == ARB_IDLE) && (state_nx == ARB_BUSY);

  always_comb begin
    state_nx  = state;
    rsp_ready = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    unique case (state)
      ARB_IDLE: begin
        if (s0.valid || s1.valid) state_nx = ARB_BUSY;
      end
      ARB_BUSY: begin
        // ready beats a coincident timeout
        if (mem.ready) begin
          state_nx  = ARB_IDLE;
          rsp_ready = 1'b1;
          rsp_rdata = mem.rdata;
        end else if (timeout) begin
          state_nx = ARB_ABORT;
        end
      end
      ARB_ABORT: begin
        state_nx  = ARB_IDLE;
        rsp_ready = 1'b1;
        rsp_err   = 1'b1;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      grant   <= PORT_D;
      rr_last <= 1'b1;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        grant   <= winner;
        addr_q  <= winner ? s1.addr  : s0.addr;
        wdata_q <= winner ? s1.wdata : s0.wdata;
        we_q    <= winner ? s1.we    : s0.we;
        cnt     <= '0;
      end else if (in_busy && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (rsp_ready) rr_last <= grant;
    end
  end

  assign busy      = (state != ARB_IDLE);
  assign mem.valid = in_busy;
  assign mem.addr  = in_busy ? addr_q  : '0;
  assign mem.wdata = in_busy ? wdata_q : '0;
  assign mem.we    = in_busy ? we_q    : '0;

  assign s0.ready = rsp_ready && (grant == PORT_D);
  assign s0.err   = rsp_err   && (grant == PORT_D);
  assign s0.rdata = (grant == PORT_D) ? rsp_rdata : '0;
  assign s1.ready = rsp_ready && (grant == PORT_I);
  assign s1.err   = rsp_err   && (grant == PORT_I);
  assign s1.rdata = (grant == PORT_I) ? rsp_rdata : '0;

endmodule
